ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 28_000_000, meaning the clk28 frequency in Hz, used to derive all timing constants.
REQ-002 The block SHALL have parameter INHIBIT_US, default 120, meaning the host clock-inhibit time in microseconds.
REQ-003 The block SHALL have parameter TIMEOUT_MS, default 20, meaning the transaction watchdog in milliseconds.
REQ-004 clk28  in  1  system clock; the only clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
REQ-007 ps2_dat_in  in  1  raw PS/2 data line, asynchronous.
REQ-008 ps2_clk_oe  out  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-009 ps2_dat_oe  out  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-010 tx_data  in  8  command byte to send.
REQ-011 tx_valid  in  1  request; byte is accepted on a cycle where tx_valid and tx_ready are both 1.
REQ-012 tx_ready  out  1  1 only in IDLE.
REQ-013 busy  out  1  1 in every state except IDLE; the PS/2 receiver discards frames while busy is 1.
REQ-014 tx_done  out  1  one-cycle pulse at transaction end.
REQ-015 tx_err  out  1  valid only with tx_done; 1 = NACK or timeout.

Function
REQ-016 Inputs SHALL be 2-FF synchronised, then filtered; a filtered level changes only after 4 consecutive equal samples. Falling-edge detection on the filtered clock SHALL be a one-cycle strobe.
REQ-017 The FSM states SHALL be IDLE, INHIBIT, REQ, SEND, ACK, RELEASE and FINISH.
REQ-018 IDLE: on handshake, latch tx_data and compute odd parity (~^tx_data) into an 11-bit shift frame {1 stop, parity, data[7:0] LSB first}, then go to INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe=1 for T_INH = CLK_FREQ/1_000_000*INHIBIT_US cycles (3360 at default). ps2_dat_oe SHALL go to 1 in the last cycle, then go to REQ.
REQ-020 REQ: ps2_clk_oe=0 and ps2_dat_oe=1 (start bit). On the 1st clock falling edge, drive bit0 and go to SEND.
REQ-021 SEND: on each clock falling edge, shift out the next frame bit; ps2_dat_oe = ~bit. After the stop bit is driven (dat released, edge 10), go to ACK.
REQ-022 ACK: on the 11th falling edge, sample filtered data; 0 = ACK, 1 = NACK (error). Then go to RELEASE.
REQ-023 RELEASE: wait until filtered clk and data are both 1, then go to FINISH.
REQ-024 FINISH: assert tx_done=1 (and tx_err) for one cycle, then return to IDLE.
REQ-025 Watchdog: a counter starts at entry to REQ and counts to CLK_FREQ/1000*TIMEOUT_MS (560000 at default, 20-bit counter). On expiry in any state other than IDLE, INHIBIT or FINISH, both oe SHALL go to 0 and the FSM SHALL go to FINISH with tx_err=1.
REQ-026 A request while the device is mid-frame (clk low seen in IDLE) SHALL still be accepted; host inhibit has priority. The interrupted device frame is lost.
REQ-027 tx_valid SHALL be ignored while busy=1; the latched byte SHALL not change.
REQ-028 ps2_clk_oe and ps2_dat_oe SHALL never both be 1 except during the last INHIBIT cycle.

Reset
REQ-029 On rst_n=0, the block SHALL asynchronously enter IDLE with ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1 after release, and busy, tx_done, tx_err, counters and filters cleared (filtered lines = 1).
REQ-030 A reset mid-transaction SHALL release both lines within the same cycle and produce no tx_done.

Structure
REQ-031 The shared package common SHALL hold PS/2 command constants (PS2_CMD_SETLED=8'hED, PS2_CMD_RESET=8'hFF). The state enum SHALL stay local to the module.
REQ-032 One sub-module ps2_line_filter (sync, 4-sample filter, fall strobe) SHALL be instantiated for clk and for data.

Verification
REQ-033 Send 8'hED with a device model clocking at 12 kHz and giving ACK -> 120 us clk inhibit, start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done with tx_err=0; 3360-cycle inhibit measured.
REQ-034 Send 8'h00 -> parity bit 1; send 8'h01 -> parity bit 0.
REQ-035 Device holds data high at the 11th edge -> tx_done with tx_err=1.
REQ-036 Device never clocks -> tx_done with tx_err=1 at 560000 cycles after REQ; both oe=0.
REQ-037 Assert rst_n=0 during bit 4 -> oe lines 0 immediately, no tx_done, and tx_ready=1 after release.
REQ-038 Apply tx_valid during a device frame, plus a 2-cycle clk glitch in SEND -> inhibit starts at once; the glitch is filtered with no extra shift.

Source files
------------

// File: rtl/common.sv
// Shared PS/2 definitions for the host-side blocks.
//
// Contents:
//   PS2_CMD_SETLED, PS2_CMD_RESET  - host-to-device command bytes
//   odd_parity()                   - parity bit that makes data+parity odd
package common;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    // PS/2 frames carry odd parity: the bit is 1 when the data has an even
    // number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between a command source and ps2_host_tx.
//
// Signals:
//   tx_data   command byte to send
//   tx_valid  request; accepted when tx_valid and tx_ready are both 1
//   tx_ready  transmitter idle and able to accept a byte
//   busy      transaction in progress (receiver discards frames meanwhile)
//   tx_done   one-cycle pulse at the end of a transaction
//   tx_err    qualifies tx_done: 1 = NACK or watchdog timeout
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchroniser, a glitch filter that
// moves the filtered level only after 4 consecutive equal samples that
// differ from it, and a one-cycle falling-edge strobe.
//
// Ports:
//   clk28  system clock
//   rst_n  asynchronous active-low reset (filtered level resets to 1)
//   raw    asynchronous line input
//   level  filtered line level
//   fall   one-cycle strobe on a filtered 1 -> 0 transition
module ps2_line_filter (
    input  logic clk28,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic [1:0] sync_q;
    logic [1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= 2'd0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            fall   <= 1'b0;
            if (sync_q[1] != level) begin
                // Fourth differing sample in a row: accept the new level.
                if (cnt_q == 2'd3) begin
                    level <= sync_q[1];
                    cnt_q <= 2'd0;
                    fall  <= level;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                end
            end else begin
                cnt_q <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues the request-to-
// send (start bit), shifts the byte out on device clock falling edges,
// samples the device ACK and reports completion. A watchdog started on
// entry to REQ aborts a stalled transaction.
//
// Ports:
//   clk28, rst_n             system clock, asynchronous active-low reset
//   ps2_clk_in, ps2_dat_in   raw PS/2 lines (asynchronous)
//   ps2_clk_oe, ps2_dat_oe   1 = pull the line low (open-drain)
//   tx                       byte handshake and status (ps2_host_tx_if.slave)
module ps2_host_tx
    import common::*;
#(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 20
) (
    input  logic         clk28,
    input  logic         rst_n,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe,
    ps2_host_tx_if.slave tx
);

    localparam int T_INH = CLK_FREQ / 1_000_000 * INHIBIT_US;
    localparam int T_WDG = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int INH_W = $clog2(T_INH + 1);
    localparam int WDG_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        RELEASE,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      frame_q;      // {stop, parity, data[7:0], start}, bit 0 on the wire
    logic [3:0]       bit_cnt_q;    // falling edges seen since REQ
    logic [INH_W-1:0] inh_cnt_q;
    logic [WDG_W-1:0] wdg_cnt_q;
    logic             err_q;

    logic clk_f, clk_fall;
    logic dat_f, dat_fall_unused;
    logic inh_last, wdg_expired;

    ps2_line_filter u_clk_filt (
        .clk28 (clk28),
        .rst_n (rst_n),
        .raw   (ps2_clk_in),
        .level (clk_f),
        .fall  (clk_fall)
    );

    ps2_line_filter u_dat_filt (
        .clk28 (clk28),
        .rst_n (rst_n),
        .raw   (ps2_dat_in),
        .level (dat_f),
        .fall  (dat_fall_unused)
    );

    assign inh_last    = (inh_cnt_q == INH_W'(T_INH - 1));
    assign wdg_expired = (wdg_cnt_q == WDG_W'(T_WDG - 1));

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tx.tx_valid) state_d = INHIBIT;
            INHIBIT: if (inh_last)    state_d = REQ;
            REQ: begin
                if (wdg_expired)   state_d = FINISH;
                else if (clk_fall) state_d = SEND;
            end
            SEND: begin
                // The 10th edge drives the stop bit; the next edge is the ACK.
                if (wdg_expired)                          state_d = FINISH;
                else if (clk_fall && bit_cnt_q == 4'd9)   state_d = ACK;
            end
            ACK: begin
                if (wdg_expired)   state_d = FINISH;
                else if (clk_fall) state_d = RELEASE;
            end
            RELEASE: begin
                if (wdg_expired)        state_d = FINISH;
                else if (clk_f && dat_f) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_dat_oe  = 1'b0;
        tx.tx_ready = (state_q == IDLE);
        tx.busy     = (state_q != IDLE);
        tx.tx_done  = (state_q == FINISH);
        tx.tx_err   = (state_q == FINISH) && err_q;
        unique case (state_q)
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                // Start bit goes low only in the last inhibit cycle, so clk
                // and data are never pulled together outside that cycle.
                ps2_dat_oe = inh_last;
            end
            REQ, SEND, ACK: ps2_dat_oe = ~frame_q[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            frame_q   <= '1;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            wdg_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    inh_cnt_q <= '0;
                    // Accepted regardless of line activity: a device frame in
                    // progress is abandoned in favour of the host inhibit.
                    if (tx.tx_valid) begin
                        frame_q   <= {1'b1, odd_parity(tx.tx_data), tx.tx_data, 1'b0};
                        bit_cnt_q <= '0;
                        err_q     <= 1'b0;
                    end
                end
                INHIBIT: begin
                    inh_cnt_q <= inh_cnt_q + INH_W'(1);
                    wdg_cnt_q <= '0;
                end
                REQ, SEND, ACK, RELEASE: begin
                    wdg_cnt_q <= wdg_cnt_q + WDG_W'(1);
                    if (wdg_expired) begin
                        err_q <= 1'b1;
                    end else if (clk_fall) begin
                        if (state_q == ACK) begin
                            err_q <= dat_f;  // device holds data low to ACK
                        end else if (state_q != RELEASE) begin
                            // Shift in 1s so the line is released after stop.
                            frame_q   <= {1'b1, frame_q[10:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a 12 kHz PS/2 device model on
// wired-AND lines, a scoreboard of expected frames/error flags, and one
// default-parameter instance for the full-rate inhibit length.
module tb_ps2_host_tx;
    import common::*;

    localparam int TB_CLK     = 2_000_000;
    localparam int INH_US     = 120;
    localparam int TMO_MS     = 10;
    localparam int T_INH      = TB_CLK / 1_000_000 * INH_US;  // 240
    localparam int T_WDG      = TB_CLK / 1000 * TMO_MS;       // 20000
    localparam int T_INH_FULL = 3360;
    localparam int HALF       = TB_CLK / 24000;               // 12 kHz half period

    typedef struct {
        logic [10:0] frame;
        logic        err;
    } exp_t;

    logic clk28      = 1'b0;
    logic rst_n      = 1'b0;
    logic rst_n_full = 1'b0;
    logic dev_clk    = 1'b1;
    logic dev_dat    = 1'b1;
    logic clk_oe, dat_oe, clk_line, dat_line;
    logic full_clk_oe, full_dat_oe, full_clk_line, full_dat_line;

    int   checks     = 0;
    int   failures   = 0;
    int   done_count = 0;
    int   both_cnt   = 0;
    exp_t exp_q[$];
    logic obs_err_q[$];

    ps2_host_tx_if tx_if ();
    ps2_host_tx_if full_if ();

    assign clk_line      = ~clk_oe & dev_clk;
    assign dat_line      = ~dat_oe & dev_dat;
    assign full_clk_line = ~full_clk_oe;
    assign full_dat_line = ~full_dat_oe;

    ps2_host_tx #(
        .CLK_FREQ   (TB_CLK),
        .INHIBIT_US (INH_US),
        .TIMEOUT_MS (TMO_MS)
    ) dut (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (clk_oe),
        .ps2_dat_oe (dat_oe),
        .tx         (tx_if)
    );

    ps2_host_tx dut_full (
        .clk28      (clk28),
        .rst_n      (rst_n_full),
        .ps2_clk_in (full_clk_line),
        .ps2_dat_in (full_dat_line),
        .ps2_clk_oe (full_clk_oe),
        .ps2_dat_oe (full_dat_oe),
        .tx         (full_if)
    );

    always #5 clk28 = ~clk28;

    always @(negedge clk28) begin
        if (tx_if.tx_done === 1'b1) begin
            done_count++;
            obs_err_q.push_back(tx_if.tx_err);
        end
        if (clk_oe === 1'b1 && dat_oe === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] d, input logic exp_err, input bit push);
        exp_t e;
        @(negedge clk28);
        check("ready_before_req", 32'(tx_if.tx_ready), 1);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        @(posedge clk28);
        #1;
        tx_if.tx_valid = 1'b0;
        check("busy_after_accept", 32'(tx_if.busy), 1);
        check("inhibit_at_once", 32'(clk_oe), 1);
        if (push) begin
            e.frame = model_frame(d);
            e.err   = exp_err;
            exp_q.push_back(e);
        end
    endtask

    // Returns on the first cycle of REQ (clk released, start bit driven).
    task automatic dev_wait_start(output int inh_cycles, output bit ok);
        inh_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < T_INH + 1000; i++) begin
            @(negedge clk28);
            if (clk_oe) inh_cycles++;
            else if (dat_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic dev_clock(input int n_falls, input bit ack, input int glitch_at,
                             output logic [10:0] cap);
        cap    = '1;
        cap[0] = dat_line;
        repeat (50) @(negedge clk28);
        for (int i = 0; i < n_falls; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk28);
            if (i < 10) cap[i+1] = dat_line;
            dev_clk = 1'b1;
            if (i == 9)  dev_dat = ack ? 1'b0 : 1'b1;
            if (i == 10) dev_dat = 1'b1;
            if (i == glitch_at) begin
                repeat (30) @(negedge clk28);
                dev_clk = 1'b0;
                repeat (2) @(negedge clk28);
                dev_clk = 1'b1;
                repeat (HALF - 32) @(negedge clk28);
            end else begin
                repeat (HALF) @(negedge clk28);
            end
        end
    endtask

    task automatic expect_done(input string tag, input bit chk_frame,
                               input logic [10:0] cap, input int budget);
        exp_t e;
        logic obs;
        for (int i = 0; i < budget && obs_err_q.size() == 0; i++) @(negedge clk28);
        check({tag, "_done_seen"}, obs_err_q.size(), 1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        if (obs_err_q.size() != 0) begin
            obs = obs_err_q.pop_front();
            check({tag, "_err"}, 32'(obs), 32'(e.err));
            if (chk_frame) check({tag, "_frame"}, 32'(cap), 32'(e.frame));
        end
    endtask

    initial begin
        logic [10:0] cap;
        int          inh, n, fb, dc;
        bit          ok;

        tx_if.tx_valid   = 1'b0;
        tx_if.tx_data    = 8'h00;
        full_if.tx_valid = 1'b0;
        full_if.tx_data  = 8'h00;
        repeat (5) @(negedge clk28);
        rst_n      = 1'b1;
        rst_n_full = 1'b1;
        @(negedge clk28);

        check("rst_ready", 32'(tx_if.tx_ready), 1);
        check("rst_busy", 32'(tx_if.busy), 0);
        check("rst_done", 32'(tx_if.tx_done), 0);
        check("rst_err", 32'(tx_if.tx_err), 0);
        check("rst_clk_oe", 32'(clk_oe), 0);
        check("rst_dat_oe", 32'(dat_oe), 0);

        // SETLED with ACK; a competing request is held during the transfer.
        send(PS2_CMD_SETLED, 1'b0, 1'b1);
        tx_if.tx_data  = PS2_CMD_RESET;
        tx_if.tx_valid = 1'b1;
        dev_wait_start(inh, ok);
        tx_if.tx_valid = 1'b0;
        check("ed_req_reached", 32'(ok), 1);
        check("ed_inhibit_cycles", inh, T_INH);
        check("ed_both_oe_once", both_cnt, 1);
        dev_clock(11, 1'b1, -1, cap);
        expect_done("ed", 1'b1, cap, 2000);
        check("ed_frame_literal", 32'(cap), 32'(11'b11111011010));
        check("ed_single_done", done_count, 1);

        // Parity corner cases.
        send(8'h00, 1'b0, 1'b1);
        dev_wait_start(inh, ok);
        dev_clock(11, 1'b1, -1, cap);
        expect_done("d00", 1'b1, cap, 2000);
        check("d00_parity", 32'(cap[9]), 1);

        send(8'h01, 1'b0, 1'b1);
        dev_wait_start(inh, ok);
        dev_clock(11, 1'b1, -1, cap);
        expect_done("d01", 1'b1, cap, 2000);
        check("d01_parity", 32'(cap[9]), 0);

        // NACK: device leaves data high at the 11th edge.
        send(8'h3C, 1'b1, 1'b1);
        dev_wait_start(inh, ok);
        dev_clock(11, 1'b0, -1, cap);
        expect_done("nack", 1'b1, cap, 2000);

        // Watchdog: device never clocks.
        send(8'hF0, 1'b1, 1'b1);
        dev_wait_start(inh, ok);
        check("tmo_req_reached", 32'(ok), 1);
        n = 0;
        for (int i = 0; i < T_WDG + 100; i++) begin
            @(negedge clk28);
            n++;
            if (tx_if.tx_done) break;
        end
        check("tmo_cycles", n, T_WDG);
        check("tmo_clk_oe", 32'(clk_oe), 0);
        check("tmo_dat_oe", 32'(dat_oe), 0);
        expect_done("tmo", 1'b0, cap, 10);

        // Reset while data bit 4 (a 0) is driven.
        send(8'hA5, 1'b0, 1'b0);
        dev_wait_start(inh, ok);
        dev_clock(5, 1'b1, -1, cap);
        check("rst_mid_pre_dat_oe", 32'(dat_oe), 1);
        dc = done_count;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_clk_oe", 32'(clk_oe), 0);
        check("rst_mid_dat_oe", 32'(dat_oe), 0);
        repeat (3) @(negedge clk28);
        rst_n = 1'b1;
        repeat (20) @(negedge clk28);
        check("rst_mid_ready", 32'(tx_if.tx_ready), 1);
        check("rst_mid_busy", 32'(tx_if.busy), 0);
        check("rst_mid_no_done", done_count, dc);

        // Request during a device frame, then a 2-cycle clk glitch in SEND.
        dev_dat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk28);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk28);
        end
        dev_clk = 1'b0;
        repeat (10) @(negedge clk28);
        send(8'h96, 1'b0, 1'b1);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        dev_wait_start(inh, ok);
        check("glitch_req_reached", 32'(ok), 1);
        dev_clock(11, 1'b1, 3, cap);
        expect_done("glitch", 1'b1, cap, 2000);
        check("both_oe_total", both_cnt, 7);

        // Full-rate inhibit on the default-parameter instance.
        @(negedge clk28);
        full_if.tx_data  = PS2_CMD_RESET;
        full_if.tx_valid = 1'b1;
        @(posedge clk28);
        #1;
        full_if.tx_valid = 1'b0;
        n  = 0;
        fb = 0;
        for (int i = 0; i < T_INH_FULL + 500; i++) begin
            @(negedge clk28);
            if (full_clk_oe) begin
                n++;
                if (full_dat_oe) fb++;
            end else begin
                break;
            end
        end
        check("full_inhibit_cycles", n, T_INH_FULL);
        check("full_both_oe_once", fb, 1);
        check("full_req_start_bit", 32'(full_dat_oe), 1);
        rst_n_full = 1'b0;
        #1;
        check("full_rst_dat_oe", 32'(full_dat_oe), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
